moving_avg_filter: RTL

- Parametrised sliding-window averaging filter for a sample stream.
- Next generation of the 8-bit fixed-window Average block. Adds configurable sample width and window depth, an input qualifier, a runtime mode select (plain mean or nearest sample), a window flush, and a fill status.
- Sits between a sample source and a downstream checker/consumer. Produces one registered result per accepted sample once the window is full.

---
 rtl/moving_avg_filter.sv | 71 +++++++
 1 files changed

// File: rtl/moving_avg_filter.sv
// moving_avg_filter: sliding-window mean / nearest-sample filter; define AVG_ROUND_EN for a round-half-up mean
module moving_avg_filter #(
  parameter int DATA_W = 8,
  parameter int WIN    = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              mode,
  input  logic              flush,
  output logic              valid,
  output logic [DATA_W-1:0] out,
  output logic              full
);
  localparam int SW = DATA_W + $clog2(WIN + 1);
  localparam int PW = $clog2(WIN);
  localparam int FW = $clog2(WIN + 1);
  localparam logic [SW-1:0] WIN_S    = SW'(WIN);
  localparam logic [PW-1:0] PTR_MAX  = PW'(WIN - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(WIN);
`ifdef AVG_ROUND_EN
  localparam logic [SW-1:0] HALF = SW'(WIN / 2);
`else
  localparam logic [SW-1:0] HALF = '0;
`endif
  logic [DATA_W-1:0] buf_q [WIN];
  logic [DATA_W-1:0] buf_d [WIN];
  logic [PW-1:0]     ptr_q, ptr_d, ptr_b;
  logic [FW-1:0]     fill_q, fill_d, fill_b;
  logic [SW-1:0]     sum_q, sum_d, sum_b;
  logic [DATA_W-1:0] out_q, out_d, oldest, mean, near;
  logic              valid_q, valid_d;
  // flush clears first, so a sample accepted alongside it becomes entry 0
  always_comb begin
    ptr_b   = flush ? '0 : ptr_q;
    fill_b  = flush ? '0 : fill_q;
    sum_b   = flush ? '0 : sum_q;
    oldest  = (fill_b == FILL_MAX) ? buf_q[ptr_b] : '0;
    buf_d   = buf_q;
    if (in_valid) buf_d[ptr_b] = data;
    sum_d   = in_valid ? sum_b + SW'(data) - SW'(oldest) : sum_b;
    fill_d  = (in_valid && fill_b != FILL_MAX) ? fill_b + FW'(1) : fill_b;
    ptr_d   = in_valid ? ((ptr_b == PTR_MAX) ? '0 : ptr_b + PW'(1)) : ptr_b;
    mean    = DATA_W'((sum_d + HALF) / WIN_S);
    near    = '0;
    for (int i = 0; i < WIN; i++)
      if (buf_d[i] <= mean && buf_d[i] > near) near = buf_d[i];
    valid_d = in_valid && fill_d == FILL_MAX;
    out_d   = valid_d ? (mode ? near : mean) : out_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      fill_q  <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) buf_q <= buf_d;
  assign valid = valid_q;
  assign out   = out_q;
  assign full  = fill_q == FILL_MAX;
endmodule
